// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one serial bus master port.
// Grants one requester at a time, issues its command pulse, tracks word handshakes, releases on done/timeout.
module serial_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_MASTERS-1:0]           req,
  input  logic [2*NUM_MASTERS-1:0]         req_instr,
  input  logic [BURST_LEN*NUM_MASTERS-1:0] req_burst,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic [$clog2(NUM_MASTERS)-1:0]   owner,
  output logic                             busy,
  output logic [1:0]                       bus_instruction,
  output logic [BURST_LEN-1:0]             bus_burst_num,
  input  logic                             bus_valid,
  input  logic                             bus_ready,
  output logic                             done,
  output logic                             timeout_err
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(DATA_LEN + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_WORD = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] RELEASE   = 3'd4;

  logic [2:0]             state;
  logic [OW-1:0]          ptr;
  logic [BURST_LEN-1:0]   burst_lat;
  logic [BURST_LEN:0]     word_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [BW-1:0]          bit_cnt;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] sel_onehot;
  logic [OW-1:0]          sel;
  logic [OW:0]            cand;
  logic                   found;
  logic [1:0]             sel_instr;
  logic [BURST_LEN-1:0]   sel_burst;
  logic                   handshake;
  logic                   last_bit;
  logic                   last_word;
  logic                   tmo_hit;

  // Requests carrying the no-op instruction are never eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = req[i] & (req_instr[2*i +: 2] != 2'b00);
    end
  end

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, ptr} + (OW+1)'(k);
      cand = (cand >= (OW+1)'(NUM_MASTERS)) ? (cand - (OW+1)'(NUM_MASTERS)) : cand;
      if (!found && eligible[cand[OW-1:0]]) begin
        found = 1'b1;
        sel   = cand[OW-1:0];
      end else begin
        found = found;
      end
    end
  end

  // Decode the winner into a one-hot grant and pick out its command fields.
  always_comb begin
    sel_onehot = '0;
    sel_instr  = 2'b00;
    sel_burst  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel == OW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_instr     = req_instr[2*i +: 2];
        sel_burst     = req_burst[BURST_LEN*i +: BURST_LEN];
      end else begin
        sel_onehot[i] = 1'b0;
      end
    end
  end

  assign handshake = bus_valid & bus_ready;
  assign last_bit  = (bit_cnt >= BW'(DATA_LEN - 1));
  assign last_word = (word_cnt == ({1'b0, burst_lat} + (BURST_LEN+1)'(1)));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= OW'(NUM_MASTERS - 1);
      burst_lat       <= '0;
      word_cnt        <= '0;
      tmo_cnt         <= '0;
      bit_cnt         <= '0;
      grant           <= '0;
      owner           <= '0;
      busy            <= 1'b0;
      bus_instruction <= 2'b00;
      bus_burst_num   <= '0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant           <= sel_onehot;
            owner           <= sel;
            busy            <= 1'b1;
            burst_lat       <= sel_burst;
            bus_instruction <= sel_instr;
            bus_burst_num   <= sel_burst;
            state           <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          bus_instruction <= 2'b00;
          word_cnt        <= '0;
          tmo_cnt         <= '0;
          state           <= WAIT_WORD;
        end
        WAIT_WORD: begin
          if (handshake) begin
            word_cnt <= word_cnt + (BURST_LEN+1)'(1);
            bit_cnt  <= BW'(1);
            state    <= SHIFT;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (last_word) begin
              done  <= 1'b1;
              state <= RELEASE;
            end else begin
              tmo_cnt <= '0;
              state   <= WAIT_WORD;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        RELEASE: begin
          grant         <= '0;
          busy          <= 1'b0;
          bus_burst_num <= '0;
          ptr           <= owner;
          state         <= IDLE;
        end
        default: begin
          grant           <= '0;
          busy            <= 1'b0;
          bus_instruction <= 2'b00;
          bus_burst_num   <= '0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
